// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter slice.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEFAULT_NUM_REQ  = 5;
  localparam int DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/demux.sv
// Expands a grant index plus enable into a one-hot grant vector.
module demux #(
  parameter  int NUM_OUT     = 5,
  localparam int SELECT_BITS = $clog2(NUM_OUT)
) (
  input  logic [SELECT_BITS-1:0] i_select,
  input  logic                   i_enable,
  output logic [NUM_OUT-1:0]     o_out
);

  // Decode the select index, gated by enable.
  always_comb begin
    o_out = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      o_out[k] = i_enable && (i_select == SELECT_BITS'(k));
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: first set request after i_last (wrapping), optionally
// excluding one index. Double-width rotate followed by a priority encode.
module rr_pick #(
  parameter  int NUM_REQ     = 5,
  localparam int SELECT_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [SELECT_BITS-1:0] i_last,
  input  logic [SELECT_BITS-1:0] i_mask_idx,
  input  logic                   i_mask_en,
  output logic [SELECT_BITS-1:0] o_idx,
  output logic                   o_valid
);

  // One extra bit holds start + offset, which reaches at most 2*NUM_REQ-1.
  localparam int SUM_W = SELECT_BITS + 1;

  logic [NUM_REQ-1:0]   mask_s;
  logic [NUM_REQ-1:0]   req_m_s;
  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [SUM_W-1:0]     start_s;
  logic [SUM_W-1:0]     pos_s;
  logic [SUM_W-1:0]     sum_s;
  logic [SUM_W-1:0]     wrap_s;

  // Mask, rotate so index last+1 lands at bit 0, then take the lowest set bit.
  always_comb begin
    mask_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      mask_s[k] = i_mask_en && (i_mask_idx == SELECT_BITS'(k));
    end
    req_m_s = i_req & ~mask_s;
    start_s = SUM_W'(i_last) + SUM_W'(1);
    dbl_s   = {req_m_s, req_m_s};
    rot_s   = NUM_REQ'(dbl_s >> start_s);
    pos_s   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos_s = rot_s[k] ? SUM_W'(k) : pos_s;
    end
    sum_s  = start_s + pos_s;
    wrap_s = (sum_s >= SUM_W'(NUM_REQ)) ? (sum_s - SUM_W'(NUM_REQ)) : sum_s;
  end

  assign o_idx   = SELECT_BITS'(wrap_s);
  assign o_valid = |req_m_s;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with release/hold-timeout, driving a downstream demux
// with a registered grant index and grant-valid.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ     = DEFAULT_NUM_REQ,
  parameter  int MAX_HOLD    = DEFAULT_MAX_HOLD,
  localparam int SELECT_BITS = $clog2(NUM_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic                   i_release,
  output logic [SELECT_BITS-1:0] o_select,
  output logic                   o_enable,
  output logic                   o_timeout
);

  localparam int                     CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]       CNT_MAX   = CNT_W'(MAX_HOLD - 1);
  localparam logic [SELECT_BITS-1:0] LAST_INIT = SELECT_BITS'(NUM_REQ - 1);

  arb_state_t             state_q, state_d;
  logic [SELECT_BITS-1:0] sel_q, sel_d;
  logic [SELECT_BITS-1:0] last_q, last_d;
  logic                   en_q, en_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   in_grant_s;
  logic                   release_s;
  logic                   expire_s;
  logic                   end_s;
  logic [SELECT_BITS-1:0] pick_last_s;
  logic [SELECT_BITS-1:0] pick_idx_s;
  logic                   pick_valid_s;

  assign in_grant_s = (state_q == GRANT);
  assign release_s  = in_grant_s && i_release;
  assign expire_s   = in_grant_s && !i_release && (cnt_q == CNT_MAX);
  assign end_s      = release_s || expire_s;

  // While granted, the pick is only consumed on handoff, where the owner
  // becomes the new lowest-priority source and is excluded from the pick.
  assign pick_last_s = in_grant_s ? sel_q : last_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req      (i_req),
    .i_last     (pick_last_s),
    .i_mask_idx (sel_q),
    .i_mask_en  (in_grant_s),
    .o_idx      (pick_idx_s),
    .o_valid    (pick_valid_s)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= LAST_INIT;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      en_q      <= en_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_valid_s ? GRANT : IDLE;
      GRANT:   state_d = (end_s && !pick_valid_s) ? IDLE : GRANT;
      default: state_d = IDLE;
    endcase
  end

  // Grant, pointer, hold counter and timeout pulse.
  always_comb begin
    sel_d     = sel_q;
    last_d    = last_q;
    en_d      = en_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_valid_s) begin
          sel_d = pick_idx_s;
          en_d  = 1'b1;
        end else begin
          en_d  = 1'b0;
        end
      end
      GRANT: begin
        if (end_s) begin
          last_d    = sel_q;
          cnt_d     = '0;
          timeout_d = expire_s;
          if (pick_valid_s) begin
            sel_d = pick_idx_s;
            en_d  = 1'b1;
          end else begin
            en_d  = 1'b0;
          end
        end else begin
          en_d  = 1'b1;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
        end
      end
      default: begin
        en_d  = 1'b0;
        cnt_d = '0;
      end
    endcase
  end

  assign o_select  = sel_q;
  assign o_enable  = en_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench: rr_arbiter feeding demux, table vectors plus hand-written
// timeout sequences, all expectations computed by hand.
module tb_rr_arbiter;

  localparam int N  = 5;
  localparam int MH = 4;
  localparam int SB = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          rel;
  logic [SB-1:0] sel;
  logic          en;
  logic          to;
  logic [N-1:0]  onehot;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_release (rel),
    .o_select  (sel),
    .o_enable  (en),
    .o_timeout (to)
  );

  demux #(.NUM_OUT(N)) u_demux (
    .i_select (sel),
    .i_enable (en),
    .o_out    (onehot)
  );

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          rel;
    logic          en;
    logic [SB-1:0] sel;
    logic          to;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [N-1:0] q, input logic rl,
                      input logic e_en, input logic [SB-1:0] e_sel, input logic e_to);
    logic [N-1:0] e_oh;
    rst = r;
    req = q;
    rel = rl;
    @(posedge clk);
    #1;
    e_oh = '0;
    if (e_en) e_oh[e_sel] = 1'b1;
    check({tag, " enable"},  32'(en),     32'(e_en));
    check({tag, " select"},  32'(sel),    32'(e_sel));
    check({tag, " timeout"}, 32'(to),     32'(e_to));
    check({tag, " onehot"},  32'(onehot), 32'(e_oh));
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    rel = 1'b0;

    //           rst   req        rel   en    sel   to
    vecs[0]  = '{1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 5'b10110, 1'b0, 1'b1, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 5'b10110, 1'b0, 1'b1, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 5'b10110, 1'b1, 1'b1, 3'd2, 1'b0};
    vecs[4]  = '{1'b0, 5'b10110, 1'b1, 1'b1, 3'd4, 1'b0};
    vecs[5]  = '{1'b0, 5'b10110, 1'b1, 1'b1, 3'd1, 1'b0};
    vecs[6]  = '{1'b0, 5'b00001, 1'b0, 1'b1, 3'd1, 1'b0};
    vecs[7]  = '{1'b0, 5'b00001, 1'b1, 1'b1, 3'd0, 1'b0};
    vecs[8]  = '{1'b0, 5'b00001, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 5'b00001, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[12] = '{1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{1'b0, 5'b00100, 1'b1, 1'b1, 3'd2, 1'b0};
    vecs[14] = '{1'b0, 5'b01000, 1'b1, 1'b1, 3'd3, 1'b0};
    vecs[15] = '{1'b1, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[16] = '{1'b0, 5'b11111, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[17] = '{1'b0, 5'b11111, 1'b1, 1'b1, 3'd1, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].rel,
           vecs[i].en, vecs[i].sel, vecs[i].to);
    end

    // Timeout handoff 0 -> 1, then 1 -> 0 after another full hold.
    step("to_rst", 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step($sformatf("to_hold0_c%0d", c), 1'b0, 5'b00011, 1'b0, 1'b1, 3'd0, 1'b0);
    end
    step("to_fire1", 1'b0, 5'b00011, 1'b0, 1'b1, 3'd1, 1'b1);
    for (int c = 6; c <= 8; c++) begin
      step($sformatf("to_hold1_c%0d", c), 1'b0, 5'b00011, 1'b0, 1'b1, 3'd1, 1'b0);
    end
    step("to_fire2", 1'b0, 5'b00011, 1'b0, 1'b1, 3'd0, 1'b1);

    // Release on the timeout cycle wins: handoff without a timeout pulse.
    step("co_rst", 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step($sformatf("co_hold_c%0d", c), 1'b0, 5'b00011, 1'b0, 1'b1, 3'd0, 1'b0);
    end
    step("co_release", 1'b0, 5'b00011, 1'b1, 1'b1, 3'd1, 1'b0);

    // Lone requester times out: grant drops with the pulse, then re-grants.
    step("lone_rst", 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step($sformatf("lone_hold_c%0d", c), 1'b0, 5'b00001, 1'b0, 1'b1, 3'd0, 1'b0);
    end
    step("lone_drop", 1'b0, 5'b00001, 1'b0, 1'b0, 3'd0, 1'b1);
    step("lone_regrant", 1'b0, 5'b00001, 1'b0, 1'b1, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter placed directly upstream of `demux`.
- Takes per-source request lines and drives `demux.i_select` / `demux.i_enable` with a registered grant index and grant-valid; `demux` then expands these into the one-hot grant vector.
- Holds each grant until the owner releases it or a hold timeout expires, so no source can starve the others.

Parameters:
- NUM_REQ, 5, number of requesters. Must be ≥ 2.
- MAX_HOLD, 16, maximum cycles a grant may be held before it is forcibly revoked. Must be ≥ 1.
- SELECT_BITS, $clog2(NUM_REQ), derived localparam. Not overridable; matches `demux` select width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  NUM_REQ  request vector; bit k high means source k wants the resource.
- i_release  input  1  current owner finished; sampled only in GRANT.
- o_select  output  SELECT_BITS  index of the granted source; connects to `demux.i_select`.
- o_enable  output  1  grant valid; connects to `demux.i_enable`.
- o_timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (i_rst high at a clock edge):
  - state=IDLE, o_enable=0, o_select=0, o_timeout=0, hold counter=0.
  - Priority pointer last=NUM_REQ-1, so source 0 wins first.
  - Reset overrides everything, including mid-grant; the grant drops on the following edge.
- All outputs are registered. No combinational path from i_req or i_release to any output.
- Pick function (combinational):
  - Take the first set bit of i_req, scanning indices last+1, last+2, … with wrap modulo NUM_REQ.
  - The previous owner therefore has lowest priority.
  - Result is always < NUM_REQ; it is valid only if i_req ≠ 0.
- IDLE:
  - i_release is ignored.
  - If i_req ≠ 0 → GRANT: o_select=pick, o_enable=1, counter=0. Latency is 1 cycle from request to grant.
  - Otherwise stay in IDLE, o_enable=0, o_select unchanged.
- GRANT:
  - o_select and o_enable are held. Dropping i_req[o_select] does not end the grant; only release or timeout does.
  - Counter increments each cycle, saturating at MAX_HOLD-1.
  - Release (i_release=1):
    - last=o_select.
    - If i_req excluding the owner is nonzero, the new grant goes to pick (computed with the updated last) on the next edge, state stays GRANT, counter=0. Back-to-back handoff has no idle bubble.
    - Otherwise → IDLE, o_enable=0.
    - If the owner's request is still high and no one else requests, go to IDLE for one cycle, then re-grant the same source.
  - Timeout (counter==MAX_HOLD-1 and i_release=0):
    - Same transition as release, plus o_timeout=1 for exactly one cycle.
  - Release and timeout in the same cycle: treat as release; o_timeout stays 0.
- Invariants:
  - o_enable=1 implies o_select < NUM_REQ.
  - o_timeout=1 only on a cycle where the grant changes or drops.

Decomposition:
- Shared package `arb_pkg` holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - function-free constants only; widths are derived locally.
- One natural sub-module: `rr_pick`, purely combinational.
  - Inputs: i_req, i_last, i_mask_idx, i_mask_en.
  - Outputs: o_idx, o_valid.
  - Implemented as a double-width rotate and priority-encode.
- The FSM, counter and pointer stay in `rr_arbiter`.
- Bench instantiates `rr_arbiter` feeding `demux` and checks the one-hot output.

Test Plan:
1. Reset, then i_req=5'b10110 at cycle 0 → cycle 1: o_enable=1, o_select=1, demux out=00010.
2. Hold of scenario 1; pulse i_release at cycle 3 with i_req still 10110 → cycle 4: o_select=2, no bubble. Next release → o_select=4. Next → o_select=1.
3. i_req=00001 only; grant source 0; release with i_req=00001 → one cycle o_enable=0, then o_select=0 again.
4. MAX_HOLD=4, i_req=00011, never release → source 0 granted cycles 1–4. Cycle 5: o_select=1, o_timeout=1 for that cycle only.
5. i_release and timeout coincide at cycle 4 → handoff occurs, o_timeout=0. Separately, i_release in IDLE with i_req=0 → no state change.
6. Assert i_rst while granted with o_select=3 → next cycle: o_enable=0, o_select=0. With i_req=11111 afterwards, the first grant goes to source 0.
